// File: rtl/alien_grid_renderer.sv
// Alien formation pixel source for the VGA colour path.
// Marches the grid once per N frames and tracks which aliens are alive.
module alien_grid_renderer #(
  parameter int ROWS            = 5,
  parameter int COLS            = 8,
  parameter int SX_LOG2         = 6,
  parameter int SY_LOG2         = 5,
  parameter int ALIEN_W         = 40,
  parameter int ALIEN_H         = 24,
  parameter int START_X         = 32,
  parameter int START_Y         = 48,
  parameter int STEP_X          = 4,
  parameter int STEP_Y          = 16,
  parameter int FRAMES_PER_STEP = 30,
  parameter int RIGHT_LIMIT     = 640,
  parameter int LEFT_LIMIT      = 0,
  parameter int LAND_Y          = 400,
  parameter logic [7:0] COLOR   = 8'h38
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        iHit_valid,
  input  logic [2:0]  iHit_row,
  input  logic [2:0]  iHit_col,
  output logic [7:0]  bgr_data_8,
  output logic        oDraw,
  output logic [10:0] oGridX,
  output logic [10:0] oGridY,
  output logic [5:0]  oAliveCount,
  output logic        oLanded,
  output logic        oAllDead
);

  localparam int N      = ROWS * COLS;
  localparam int GRID_W = (COLS - 1) * (2 ** SX_LOG2) + ALIEN_W;
  localparam int GRID_H = (ROWS - 1) * (2 ** SY_LOG2) + ALIEN_H;
  localparam logic [11:0] MASK_X = 12'((2 ** SX_LOG2) - 1);
  localparam logic [11:0] MASK_Y = 12'((2 ** SY_LOG2) - 1);

  typedef enum logic [1:0] {
    MARCH_RIGHT,
    MARCH_LEFT,
    LANDED,
    CLEARED
  } state_t;

  state_t      state;
  logic [10:0] grid_x;
  logic [10:0] grid_y;
  logic [N-1:0] alive;
  logic [63:0] alive_ext;
  logic [15:0] frame_cnt;
  logic        sof_q;
  logic        sof_rise;
  logic        tick;

  logic [11:0] rel_x;
  logic [11:0] rel_y;
  logic [11:0] col_w;
  logic [11:0] row_w;
  logic [5:0]  idx;
  logic        hit;

  logic        right_edge;
  logic        left_edge;
  logic [10:0] y_down;
  logic        land;
  logic [5:0]  cnt_next;

  assign oGridX    = grid_x;
  assign oGridY    = grid_y;
  assign alive_ext = 64'(alive);
  assign sof_rise  = startOfFrame & ~sof_q;
  assign tick      = sof_rise &&
                     (frame_cnt == 16'(FRAMES_PER_STEP - 1));

  always_comb begin
    rel_x = {1'b0, pixelX} - {1'b0, grid_x};
    rel_y = {1'b0, pixelY} - {1'b0, grid_y};
    col_w = rel_x >> SX_LOG2;
    row_w = rel_y >> SY_LOG2;
    idx   = 6'(32'(row_w[2:0]) * COLS + 32'(col_w[2:0]));
    hit   = (pixelX < 11'd640) && (pixelY < 11'd480) &&
            (pixelX >= grid_x) && (pixelY >= grid_y) &&
            (col_w < 12'(COLS)) && (row_w < 12'(ROWS)) &&
            ((rel_x & MASK_X) < 12'(ALIEN_W)) &&
            ((rel_y & MASK_Y) < 12'(ALIEN_H)) &&
            alive_ext[idx];
  end

  always_comb begin
    right_edge = (12'(grid_x) + 12'(GRID_W) + 12'(STEP_X)) >
                 12'(RIGHT_LIMIT);
    left_edge  = 12'(grid_x) < 12'(LEFT_LIMIT + STEP_X);
    y_down     = grid_y + 11'(STEP_Y);
    land       = (12'(y_down) + 12'(GRID_H)) >= 12'(LAND_Y);
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < N; i++) begin
      cnt_next = cnt_next + 6'(alive[i]);
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      bgr_data_8 <= 8'h00;
      oDraw      <= 1'b0;
    end else begin
      bgr_data_8 <= hit ? COLOR : 8'h00;
      oDraw      <= hit;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sof_q     <= 1'b0;
      frame_cnt <= '0;
    end else begin
      sof_q <= startOfFrame;
      if (sof_rise) begin
        frame_cnt <= tick ? '0 : frame_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      alive       <= '1;
      oAliveCount <= 6'(N);
    end else begin
      oAliveCount <= cnt_next;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (iHit_valid && iHit_row == 3'(r) &&
              iHit_col == 3'(c)) begin
            alive[r * COLS + c] <= 1'b0;
          end
        end
      end
    end
  end

  // Grid only moves on a frame tick, i.e. during blanking.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state    <= MARCH_RIGHT;
      grid_x   <= 11'(START_X);
      grid_y   <= 11'(START_Y);
      oLanded  <= 1'b0;
      oAllDead <= 1'b0;
    end else if (alive == '0) begin
      state    <= CLEARED;
      oAllDead <= 1'b1;
      oLanded  <= 1'b0;
    end else if (tick) begin
      unique case (state)
        MARCH_RIGHT: begin
          if (right_edge) begin
            grid_y  <= y_down;
            state   <= land ? LANDED : MARCH_LEFT;
            oLanded <= land;
          end else begin
            grid_x <= grid_x + 11'(STEP_X);
          end
        end
        MARCH_LEFT: begin
          if (left_edge) begin
            grid_y  <= y_down;
            state   <= land ? LANDED : MARCH_RIGHT;
            oLanded <= land;
          end else begin
            grid_x <= grid_x - 11'(STEP_X);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alien_grid_renderer.sv
// Scoreboard bench for alien_grid_renderer with a
// spec-level model of the formation and alive set.
module tb_alien_grid_renderer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] px = '0;
  logic [10:0] py = '0;
  logic        sof = 1'b0;
  logic        hv = 1'b0;
  logic [2:0]  hr = '0;
  logic [2:0]  hc = '0;
  logic [7:0]  bgr;
  logic        draw;
  logic [10:0] gx_o;
  logic [10:0] gy_o;
  logic [5:0]  cnt_o;
  logic        landed_o;
  logic        dead_o;

  alien_grid_renderer #(.FRAMES_PER_STEP(1)) dut (
    .iVGA_CLK    (clk),
    .iRST_n      (rst_n),
    .pixelX      (px),
    .pixelY      (py),
    .startOfFrame(sof),
    .iHit_valid  (hv),
    .iHit_row    (hr),
    .iHit_col    (hc),
    .bgr_data_8  (bgr),
    .oDraw       (draw),
    .oGridX      (gx_o),
    .oGridY      (gy_o),
    .oAliveCount (cnt_o),
    .oLanded     (landed_o),
    .oAllDead    (dead_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int kind;
    int a;
    int b;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // model: 0 right, 1 left, 2 landed, 3 cleared
  int gx, gy, st, cnt;
  bit alv[8][8];

  function automatic void m_reset();
    gx = 32; gy = 48; st = 0; cnt = 40;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        alv[r][c] = (r < 5) && (c < 8);
  endfunction

  function automatic int m_pix(int x, int y);
    int rx, ry, r, c;
    if (x >= 640 || y >= 480 || x < gx || y < gy) return 0;
    rx = x - gx; ry = y - gy;
    c = rx / 64; r = ry / 32;
    if (c >= 8 || r >= 5) return 0;
    if (rx % 64 >= 40 || ry % 32 >= 24) return 0;
    return int'(alv[r][c]);
  endfunction

  function automatic void m_frame();
    if (st == 0) begin
      if (gx + 488 + 4 > 640) begin
        gy += 16;
        st = (gy + 152 >= 400) ? 2 : 1;
      end else gx += 4;
    end else if (st == 1) begin
      if (gx < 4) begin
        gy += 16;
        st = (gy + 152 >= 400) ? 2 : 0;
      end else gx -= 4;
    end
  endfunction

  function automatic void m_hit(int r, int c);
    if (r < 5 && c < 8 && alv[r][c]) begin
      alv[r][c] = 0;
      cnt--;
      if (cnt == 0) st = 3;
    end
  endfunction

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int due, int kind, int a, int b);
    exp_t e;
    e.due = due; e.kind = kind; e.a = a; e.b = b;
    q.push_back(e);
  endtask

  task automatic push_reset_state();
    push(cyc, 0, 0, 0);
    push(cyc, 1, 32, 48);
    push(cyc, 2, 40, 0);
    push(cyc, 3, 0, 0);
  endtask

  task automatic chk_pix(int x, int y);
    int v;
    px = 11'(x); py = 11'(y);
    v = m_pix(x, y);
    push(cyc + 1, 0, v != 0 ? 8'h38 : 0, v);
    tick1();
  endtask

  task automatic chk_pix_c(int x, int y, int eb, int ed);
    px = 11'(x); py = 11'(y);
    push(cyc + 1, 0, eb, ed);
    tick1();
  endtask

  task automatic rand_pix();
    int y;
    y = gy + int'($urandom_range(0, 180)) - 10;
    if (y < 0) y = 0;
    chk_pix(int'($urandom_range(0, 660)), y);
  endtask

  task automatic frame(int hold);
    sof = 1'b1;
    m_frame();
    push(cyc + 1, 1, gx, gy);
    push(cyc + 1, 3, int'(st == 2), int'(st == 3));
    repeat (hold) tick1();
    sof = 1'b0;
    tick1();
    tick1();
  endtask

  task automatic hit(int r, int c);
    hv = 1'b1; hr = 3'(r); hc = 3'(c);
    m_hit(r, c);
    push(cyc + 2, 2, cnt, 0);
    push(cyc + 2, 3, int'(st == 2), int'(st == 3));
    tick1();
    hv = 1'b0;
    tick1();
    tick1();
  endtask

  string kname[4] = '{"pixel", "grid", "count", "flags"};
  int mi;
  int act_a, act_b;

  always @(negedge clk) begin
    mi = 0;
    while (mi < q.size()) begin
      if (q[mi].due <= cyc) begin
        case (q[mi].kind)
          0: begin act_a = int'(bgr); act_b = int'(draw); end
          1: begin act_a = int'(gx_o); act_b = int'(gy_o); end
          2: begin act_a = int'(cnt_o); act_b = 0; end
          default: begin
            act_a = int'(landed_o); act_b = int'(dead_o);
          end
        endcase
        tests++;
        if (act_a != q[mi].a || act_b != q[mi].b) begin
          fails++;
          $display("FAIL %s cyc=%0d: got %0d/%0d expected %0d/%0d",
                   kname[q[mi].kind], cyc, act_a, act_b,
                   q[mi].a, q[mi].b);
        end
        q.delete(mi);
      end else begin
        mi++;
      end
    end
  end

  int nf;

  initial begin
    m_reset();
    rst_n = 1'b0;
    tick1();
    tick1();
    push_reset_state();
    tick1();
    rst_n = 1'b1;
    tick1();

    chk_pix_c(32, 48, 8'h38, 1);
    chk_pix_c(72, 48, 0, 0);
    chk_pix_c(640, 48, 0, 0);
    chk_pix_c(96, 80, 8'h38, 1);
    chk_pix_c(71, 71, 8'h38, 1);
    chk_pix_c(71, 72, 0, 0);
    hit(1, 1);
    push(cyc, 2, 39, 0);
    chk_pix_c(96, 80, 0, 0);

    repeat (60) rand_pix();
    repeat (4) hit(int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)));

    nf = 0;
    while (st < 2 && nf < 1000) begin
      frame(1);
      nf++;
      if (nf == 30) push(cyc, 1, 152, 48);
      if (nf == 31) push(cyc, 1, 152, 64);
      if (nf == 69) push(cyc, 1, 0, 64);
      if (nf == 70) push(cyc, 1, 0, 80);
      if (nf % 25 == 0) repeat (4) rand_pix();
    end
    push(cyc, 3, 1, 0);
    push(cyc, 1, gx, 256);
    repeat (3) frame(1);
    repeat (30) rand_pix();

    hit(7, 0);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 8; c++) begin
        hit(r, c);
        if (r == 2 && c == 3) hit(2, 3);
      end
    end
    push(cyc, 2, 0, 0);
    push(cyc, 3, 0, 1);
    repeat (20) chk_pix_c(int'($urandom_range(0, 639)),
                          int'($urandom_range(0, 479)), 0, 0);
    frame(1);

    tick1();
    tick1();
    tick1();
    #2 rst_n = 1'b0;
    m_reset();
    push_reset_state();
    tick1();
    rst_n = 1'b1;
    tick1();

    frame(3);
    push(cyc, 1, 36, 48);
    repeat (10) frame(1);
    repeat (10) rand_pix();

    tick1();
    tick1();
    #2 rst_n = 1'b0;
    m_reset();
    push_reset_state();
    tick1();
    push_reset_state();
    rst_n = 1'b1;
    tick1();
    chk_pix_c(32, 48, 8'h38, 1);

    for (int k = 0; k < 10 && q.size() > 0; k++) tick1();
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations left, required 0",
               q.size());
      fails += q.size();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alien_grid_renderer.md
# alien_grid_renderer

Pixel-source stage feeding the VGA controller's 8-bit colour input for the space-invaders game. Given the current pixel coordinates from the sync generator, it reports whether that pixel lies on a live alien and outputs the corresponding 3-3-2 colour byte. Once per configurable number of frames, it marches the ROWS×COLS alien formation horizontally and steps it down at the screen edges. It also tracks which aliens are alive, using hit reports from the collision logic.

## Interface
- ROWS, 5, formation rows (1..8)
- COLS, 8, formation columns (1..8)
- SX_LOG2, 6, log2 of horizontal alien pitch (64 px)
- SY_LOG2, 5, log2 of vertical alien pitch (32 px)
- ALIEN_W, 40, alien width px (≤ 2^SX_LOG2)
- ALIEN_H, 24, alien height px (≤ 2^SY_LOG2)
- START_X, 32, reset grid origin X
- START_Y, 48, reset grid origin Y
- STEP_X, 4, horizontal step px
- STEP_Y, 16, descent step px
- FRAMES_PER_STEP, 30, frames between moves (≥1)
- RIGHT_LIMIT, 640, exclusive right bound
- LEFT_LIMIT, 0, inclusive left bound
- LAND_Y, 400, landing line
- COLOR, 8'h38, alien colour, {B[7:6],G[5:3],R[2:0]}
- Reset: iRST_n, asynchronous, active-low. Clock: iVGA_CLK.
- iVGA_CLK  in  1  pixel clock
- iRST_n  in  1  asynchronous active-low reset
- pixelX  in  11  current pixel X from sync generator
- pixelY  in  11  current pixel Y
- startOfFrame  in  1  high while pixel = (640,480)
- iHit_valid  in  1  kill request strobe
- iHit_row  in  3  row to kill
- iHit_col  in  3  column to kill
- bgr_data_8  out  8  pixel colour to VGA controller
- oDraw  out  1  current pixel is on a live alien
- oGridX  out  11  formation origin X
- oGridY  out  11  formation origin Y
- oAliveCount  out  6  live aliens
- oLanded  out  1  formation reached LAND_Y
- oAllDead  out  1  no aliens alive

## Operation
- Derived constants: GRID_W = (COLS-1)·2^SX_LOG2 + ALIEN_W = 488 and GRID_H = (ROWS-1)·2^SY_LOG2 + ALIEN_H = 152.
- Pixel hit test:
  - Compute relX = pixelX − gridX and relY = pixelY − gridY. All comparisons are unsigned with 12-bit headroom.
  - A hit requires all of: pixelX<640, pixelY<480, pixelX≥gridX, pixelY≥gridY, col = relX>>SX_LOG2 < COLS, row = relY>>SY_LOG2 < ROWS, relX[SX_LOG2-1:0] < ALIEN_W, relY[SY_LOG2-1:0] < ALIEN_H, and alive[row][col].
  - On a hit, bgr_data_8 = COLOR and oDraw = 1; otherwise bgr_data_8 = 8'h00 and oDraw = 0.
- Frame tick:
  - Detect the rising edge of startOfFrame.
  - frame_cnt counts 0..FRAMES_PER_STEP-1; tick fires on the edge at which it wraps to 0.
- Movement FSM, states MARCH_RIGHT, MARCH_LEFT, LANDED, CLEARED:
  - MARCH_RIGHT, on tick: if gridX+GRID_W+STEP_X > RIGHT_LIMIT, then gridY += STEP_Y and go to MARCH_LEFT (X unchanged); else gridX += STEP_X.
  - MARCH_LEFT, on tick: if gridX < LEFT_LIMIT+STEP_X, then gridY += STEP_Y and go to MARCH_RIGHT; else gridX −= STEP_X.
  - After a descent, if new gridY+GRID_H ≥ LAND_Y, go to LANDED.
  - LANDED: grid frozen, oLanded = 1, ticks ignored.
  - Any state goes to CLEARED when the alive mask is zero; CLEARED has priority over LANDED. In CLEARED, oAllDead = 1 and the grid is frozen.
- Alive mask (ROWS·COLS bits):
  - iHit_valid with row<ROWS and col<COLS clears that bit.
  - Out-of-range hits are ignored; a hit on an already-dead alien has no effect.
  - A hit and a tick in the same cycle are both applied.
- oAliveCount = registered popcount of the alive mask.

## Timing
- Reset values:
  - bgr_data_8 = 0, oDraw = 0, oLanded = 0, oAllDead = 0.
  - gridX = START_X, gridY = START_Y.
  - alive = all ones; oAliveCount = ROWS·COLS (40).
  - State MARCH_RIGHT, frame_cnt = 0, startOfFrame edge register = 0.
- bgr_data_8 and oDraw are registered: 1 cycle latency from pixelX/pixelY.
- The grid update takes effect the cycle after the startOfFrame rising edge, i.e. during blanking. The displayed frame never tears.
- Alive bit clears the cycle after iHit_valid; oAliveCount updates 1 cycle later; the CLEARED transition follows 1 cycle after the last bit clears.
- startOfFrame held high for multiple cycles counts as one frame.
- Reset asserted mid-frame restores all reset values immediately (asynchronous reset).

## Test plan
- After reset, drive (32,48) → next cycle bgr_data_8 = 8'h38, oDraw = 1. Drive (72,48) (relX=40, gap) → 8'h00. Drive (640,48) → 8'h00.
- Drive (96,80) → hit on row 1, col 1. Then pulse iHit row1/col1 → (96,80) gives 8'h00; oAliveCount = 39 two cycles after the hit.
- FRAMES_PER_STEP = 1, 30 frames → gridX = 152, gridY = 48. Frame 31 → gridX = 152, gridY = 64, state MARCH_LEFT. Then 38 frames → gridX = 0; frame 39 → gridY = 80, MARCH_RIGHT.
- Continue marching until the 13th descent → gridY = 256, oLanded = 1. Further frames leave gridX and gridY unchanged.
- Kill all 40 aliens, including one duplicate hit and one hit with row = 7 → count 40→0 ignoring the extras, oAllDead = 1, every pixel = 8'h00.
- Hold startOfFrame high for 3 cycles → single frame count. Assert iRST_n = 0 mid-march → gridX = 32, gridY = 48, mask full.
